// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - sequential instruction fetch into a PC-tagged FIFO with redirect flush
// Optional: define FETCH_HALT_ON_ECALL_EN to stop fetching once an ECALL word has been buffered.
module fetch_prefetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fetch_busy
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic {ST_FETCH = 1'b0, ST_HALTED = 1'b1} state_e;
   state_e state_q, state_d;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic          fetching, full, enq, deq, halt_hit;

   assign imem_addr  = fetch_pc_q;
   assign full       = (count_q == FULL_COUNT);
   assign inst_valid = (count_q != '0);
   assign deq        = inst_valid & inst_ready;
   assign enq        = fetching & ~redirect_valid & (~full | deq);
   assign inst       = inst_mem[rptr_q];
   assign inst_pc    = pc_mem[rptr_q];

`ifdef FETCH_HALT_ON_ECALL_EN
   assign halt_hit = enq && (imem_dout == 32'h0000_0073);
`else
   assign halt_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = ST_FETCH;
      end else if (halt_hit) begin
         state_d = ST_HALTED;
      end
   end

   // fetch_busy is forced low for the whole reset window, not just after the first edge
   always_comb begin
      fetching   = (state_q == ST_FETCH);
      fetch_busy = fetching & ~full & ~reset;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         count_d    = '0;
         wptr_d     = '0;
         rptr_d     = '0;
      end else begin
         if (enq) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wptr_d     = wptr_q + PW'(1);
         end
         if (deq) begin
            rptr_d = rptr_q + PW'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CW'(1);
         end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
         count_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         inst_mem[wptr_q] <= imem_dout;
         pc_mem[wptr_q]   <= fetch_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed and randomized bench for fetch_prefetch_unit against a queue model
module tb_fetch_prefetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_busy;
   logic        ecall_at_8;

   int checks = 0;
   int errors = 0;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_dout     (imem_dout),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .fetch_busy    (fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic e8);
      if (e8 && a == 32'h8) return 32'h0000_0073;
      return (a >> 2) + 32'h100;
   endfunction

   assign imem_dout = mem_word(imem_addr, ecall_at_8);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference model: buffered {pc, word} pairs in a queue, checked and advanced on every falling edge
   logic [63:0] mq[$];
   initial begin
      logic [31:0] mpc;
      logic [31:0] w;
      bit          mhalt;
      bit          d;
      bit          e;
      mpc   = RESET_PC;
      mhalt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mq.delete();
            mpc   = RESET_PC;
            mhalt = 0;
            chk("m_rst_valid", inst_valid, 0);
            chk("m_rst_busy", fetch_busy, 0);
            chk("m_rst_addr", imem_addr, RESET_PC);
         end else begin
            chk("m_valid", inst_valid, mq.size() != 0);
            chk("m_addr", imem_addr, mpc);
            chk("m_busy", fetch_busy, !mhalt && mq.size() < DEPTH);
            if (mq.size() != 0) begin
               chk("m_inst", inst, mq[0][31:0]);
               chk("m_inst_pc", inst_pc, mq[0][63:32]);
            end
            if (redirect_valid) begin
               mq.delete();
               mpc   = redirect_pc & ~32'h3;
               mhalt = 0;
            end else begin
               d = (mq.size() != 0) && inst_ready;
               e = !mhalt && (mq.size() < DEPTH || d);
               if (d) void'(mq.pop_front());
               if (e) begin
                  w = mem_word(mpc, ecall_at_8);
                  mq.push_back({mpc, w});
`ifdef FETCH_HALT_ON_ECALL_EN
                  if (w == 32'h0000_0073) mhalt = 1;
`endif
                  mpc = mpc + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b1;
      ecall_at_8     = 1'b0;
      step();
      step();
      reset = 1'b0;

      // streaming after reset with ready held high
      @(negedge clk);
      chk("t1_pre_valid", inst_valid, 0);
      chk("t1_pre_addr", imem_addr, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t1_valid", inst_valid, 1);
         chk("t1_pc", inst_pc, 4 * i);
         chk("t1_inst", inst, 32'h100 + i);
      end

      // fill to full, then one simultaneous enq/deq
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      step();
      redirect_valid = 1'b0;
      repeat (10) step();
      @(negedge clk);
      chk("t2_addr_hold", imem_addr, 32'h10);
      chk("t2_busy", fetch_busy, 0);
      chk("t2_head_pc", inst_pc, 32'h0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      @(negedge clk);
      chk("t2_addr_step", imem_addr, 32'h14);
      chk("t2_head_after", inst_pc, 32'h4);
      chk("t2_busy_after", fetch_busy, 0);
      step();
      inst_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_drain_pc", inst_pc, 32'h4 + 4 * i);
      end

      // redirect with three entries buffered
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0043;
      inst_ready     = 1'b1;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t3_flush_valid", inst_valid, 0);
      chk("t3_flush_addr", imem_addr, 32'h40);
      @(negedge clk);
      chk("t3_new_valid", inst_valid, 1);
      chk("t3_new_pc", inst_pc, 32'h40);
      chk("t3_new_inst", inst, 32'h110);
      @(negedge clk);
      chk("t3_next_pc", inst_pc, 32'h44);

      // address wrap at the top of the space
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_addr_top", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("t4_addr_wrap", imem_addr, 32'h0);
      chk("t4_pc_top", inst_pc, 32'hFFFF_FFFC);

      // ECALL word at address 8
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      ecall_at_8     = 1'b1;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t5_flush_valid", inst_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_pc", inst_pc, 4 * i);
      end
      chk("t5_ecall_inst", inst, 32'h0000_0073);
`ifdef FETCH_HALT_ON_ECALL_EN
      repeat (4) begin
         @(negedge clk);
         chk("t5_halt_valid", inst_valid, 0);
         chk("t5_halt_busy", fetch_busy, 0);
      end
`else
      @(negedge clk);
      chk("t5_next_pc", inst_pc, 32'hC);
`endif
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      ecall_at_8     = 1'b0;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_resume_valid", inst_valid, 1);
      chk("t5_resume_pc", inst_pc, 32'h0);

      // asynchronous reset between edges
      repeat (3) step();
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_valid", inst_valid, 0);
      chk("t6_async_addr", imem_addr, RESET_PC);
      chk("t6_async_busy", fetch_busy, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_post_valid", inst_valid, 0);
      @(negedge clk);
      chk("t6_restart_pc", inst_pc, RESET_PC);
      chk("t6_restart_inst", inst, 32'h100);

      // randomized traffic checked by the model
      for (int c = 0; c < 3000; c++) begin
         step();
         if ((c % 500) < 250) inst_ready = ($urandom_range(0, 3) != 0);
         else                 inst_ready = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
         if ((c % 100) == 0) ecall_at_8 = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 199) == 0) begin
            #2;
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
      end
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Generates word-aligned fetch addresses and samples the memory's asynchronous read data.
- Buffers fetched instructions with their PCs in a small FIFO, and hands them to the decode stage over a valid/ready handshake.
- Sits between the instruction memory and the IF/ID boundary; accepts PC redirects from branch/jump resolution.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be word aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address presented to instruction memory.
- imem_dout  input  32  instruction at imem_addr, valid combinationally in the same cycle.
- redirect_valid  input  1  one-cycle pulse: discard buffered instructions and restart at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decode stage accepts the head this cycle.
- inst  output  32  instruction at FIFO head.
- inst_pc  output  32  PC of the FIFO-head instruction.
- fetch_busy  output  1  state is FETCH and the FIFO is not full.

Behaviour:
- Clock and reset are fixed:
  - One clock, named clk.
  - reset is asynchronous and active-high.
  - While reset is high: fetch_pc=RESET_PC, FIFO count=0, read/write pointers=0, state=FETCH, inst_valid=0, fetch_busy=0.
  - inst and inst_pc are don't-care while inst_valid=0.
- Address path:
  - imem_addr = fetch_pc at all times; no other gating.
  - fetch_pc bits [1:0] are always 0.
- Dequeue:
  - deq = inst_valid & inst_ready.
  - The head advances at the clock edge.
  - inst_valid = (count != 0).
- Enqueue:
  - enq = (state==FETCH) & !redirect_valid & ((count<DEPTH) | deq).
  - On enq: write {fetch_pc, imem_dout} at the write pointer and set fetch_pc <= fetch_pc+4.
  - fetch_pc arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Latency:
  - An instruction fetched at edge N is visible at the output after edge N.
  - Empty-to-valid latency is 1 cycle; no combinational bypass from imem_dout to inst.
- Full FIFO:
  - With count==DEPTH and no deq, the FIFO stalls: fetch_pc holds and nothing is written.
  - With count==DEPTH and deq, it enqueues and dequeues in the same cycle; count is unchanged.
- Empty FIFO: a deq request is impossible because inst_valid=0; inst_ready is ignored.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Redirect (highest priority after reset):
  - At the edge with redirect_valid=1: count<=0, pointers<=0, fetch_pc<={redirect_pc[31:2],2'b00}, state<=FETCH.
  - Any simultaneous deq or enq in that cycle is discarded.
  - inst_valid is 0 in the following cycle.
  - The first instruction from the new PC appears one cycle after that.
- Redirect to the current fetch_pc is legal and still flushes.
- State machine:
  - FETCH: normal operation as above.
  - HALTED: only entered when the optional feature is enabled; no enqueue, FIFO continues to drain.
  - HALTED -> FETCH on redirect_valid or reset.
- fetch_busy = (state==FETCH) & (count<DEPTH).

Optional Feature:
- Macro: FETCH_HALT_ON_ECALL_EN.
- When defined:
  - If an enqueued word equals 32'h0000_0073 (ECALL), the state moves to HALTED at the same edge.
  - fetch_pc still increments for that enqueue, then holds.
  - The ECALL itself is buffered and delivered normally.
  - No instruction beyond it is fetched until a redirect.
- When undefined:
  - The HALTED state and its comparator are absent.
  - ECALL is treated as an ordinary word and fetch proceeds sequentially.

Test Plan:
- Reset release, memory words 0..7 = 32'h100+i, inst_ready=1 continuously -> inst_valid rises after the 1st edge; stream delivers (pc 0, 32'h100), (pc 4, 32'h101), ... in order with no bubbles.
- inst_ready=0 for 10 cycles after reset, DEPTH=4 -> count saturates at 4 and fetch_pc holds at 32'h10. On ready=1, pcs 0,4,8,C,10,14 come out consecutively; no word is duplicated or lost.
- Full FIFO with inst_ready=1 for one cycle -> simultaneous enq/deq: count stays 4, fetch_pc goes 32'h10->32'h14.
- redirect_valid with redirect_pc=32'h0000_0043 while 3 entries are buffered -> next cycle inst_valid=0; then inst_pc=32'h40 with its memory word. The 3 old entries are never presented.
- fetch_pc=32'hFFFF_FFFC via redirect -> next fetch address is 32'h0000_0000.
- Optional feature: FETCH_HALT_ON_ECALL_EN defined, word at 32'h8 = 32'h0000_0073 -> pcs 0,4,8 delivered, then inst_valid=0 indefinitely with fetch_busy=0. Redirect to 0 resumes fetch. With the macro undefined, pc 32'hC follows pc 8.
- reset asserted mid-stream, asynchronously between edges -> inst_valid drops immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.
